// File: rtl/if_fetch_if.sv
// Fetch-stage bus bundle: incrementer loop, redirect, instruction-memory
// request/response and the decode-side instruction stream.
//
// Handshakes: a transfer happens on a rising clock edge where both valid and
// ready are high. Valid never depends on ready. imem_rsp_valid_i has no ready;
// the fetch stage always accepts (or discards) a response in the cycle it is
// presented.
interface if_fetch_if #(
  parameter int DWIDTH = 32
);
  logic [DWIDTH-1:0] pc_o;
  logic [DWIDTH-1:0] pc_plus4_i;
  logic              redirect_valid_i;
  logic [DWIDTH-1:0] redirect_pc_i;
  logic              imem_req_valid_o;
  logic              imem_req_ready_i;
  logic [DWIDTH-1:0] imem_req_addr_o;
  logic              imem_rsp_valid_i;
  logic [31:0]       imem_rsp_data_i;
  logic              id_valid_o;
  logic              id_ready_i;
  logic [DWIDTH-1:0] id_pc_o;
  logic [31:0]       id_instr_o;

  modport master (
    output pc_o,
    input  pc_plus4_i,
    input  redirect_valid_i,
    input  redirect_pc_i,
    output imem_req_valid_o,
    input  imem_req_ready_i,
    output imem_req_addr_o,
    input  imem_rsp_valid_i,
    input  imem_rsp_data_i,
    output id_valid_o,
    input  id_ready_i,
    output id_pc_o,
    output id_instr_o
  );

  modport slave (
    input  pc_o,
    output pc_plus4_i,
    output redirect_valid_i,
    output redirect_pc_i,
    input  imem_req_valid_o,
    output imem_req_ready_i,
    input  imem_req_addr_o,
    output imem_rsp_valid_i,
    output imem_rsp_data_i,
    input  id_valid_o,
    output id_ready_i,
    input  id_pc_o,
    input  id_instr_o
  );
endinterface

// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the fetch PC, issues one outstanding memory
// request at a time and buffers returned words in a 2-entry FIFO for decode.
// Redirects from execute flush the FIFO and squash any in-flight response.
module if_fetch #(
  parameter int                DWIDTH   = 32,
  parameter logic [DWIDTH-1:0] RESET_PC = '0
) (
  input  logic        clk,
  input  logic        rst_n,
  if_fetch_if.master  bus,
  output logic [1:0]  dbg_state
);

  localparam logic [1:0] ST_FETCH = 2'd0;
  localparam logic [1:0] ST_WAIT  = 2'd1;
  localparam logic [1:0] ST_DROP  = 2'd2;

  logic [1:0]        state;
  logic [DWIDTH-1:0] pc;
  logic [DWIDTH-1:0] pending_pc;
  logic [DWIDTH-1:0] fifo_pc    [2];
  logic [31:0]       fifo_instr [2];
  logic              rd_ptr;
  logic              wr_ptr;
  logic [1:0]        count;

  logic redirect;
  logic rsp;
  logic req_valid;
  logic req_fire;
  logic id_valid;
  logic push;
  logic pop;

  assign redirect  = bus.redirect_valid_i;
  assign rsp       = bus.imem_rsp_valid_i;
  assign dbg_state = state;

  // Request/decode qualification; rst_n gating keeps outputs quiet in reset.
  always_comb begin
    req_valid = rst_n && (state == ST_FETCH) && (count < 2'd2) && !redirect;
    id_valid  = rst_n && (count != 2'd0) && !redirect;
    req_fire  = req_valid && bus.imem_req_ready_i;
    pop       = id_valid && bus.id_ready_i;
    push      = (state == ST_WAIT) && rsp && !redirect;
  end

  assign bus.pc_o             = pc;
  assign bus.imem_req_addr_o  = pc;
  assign bus.imem_req_valid_o = req_valid;
  assign bus.id_valid_o       = id_valid;
  assign bus.id_pc_o          = (count != 2'd0) ? fifo_pc[rd_ptr]    : '0;
  assign bus.id_instr_o       = (count != 2'd0) ? fifo_instr[rd_ptr] : '0;

  // PC, outstanding-request FSM and pending PC; redirect wins over all else.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc         <= RESET_PC;
      state      <= ST_FETCH;
      pending_pc <= '0;
    end else if (redirect) begin
      pc <= {bus.redirect_pc_i[DWIDTH-1:2], 2'b00};
      case (state)
        ST_WAIT, ST_DROP: state <= rsp ? ST_FETCH : ST_DROP;
        default:          state <= ST_FETCH;
      endcase
    end else begin
      case (state)
        ST_FETCH: begin
          if (req_fire) begin
            pending_pc <= pc;
            pc         <= bus.pc_plus4_i;
            state      <= ST_WAIT;
          end
        end
        ST_WAIT: if (rsp) state <= ST_FETCH;
        ST_DROP: if (rsp) state <= ST_FETCH;
        default: state <= ST_FETCH;
      endcase
    end
  end

  // Two-entry FIFO toward decode; a redirect empties it in one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count  <= 2'd0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        fifo_pc[i]    <= '0;
        fifo_instr[i] <= '0;
      end
    end else if (redirect) begin
      count  <= 2'd0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
    end else begin
      if (push) begin
        fifo_pc[wr_ptr]    <= pending_pc;
        fifo_instr[wr_ptr] <= bus.imem_rsp_data_i;
        wr_ptr             <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule
